// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Request/response bus between the fetch stage and instruction memory.
//
//   imem_req    fetch -> mem   request valid; held until the ready cycle
//   imem_addr   fetch -> mem   request address; stable while req is high
//   imem_rdata  mem -> fetch   instruction word, meaningful when imem_ready=1
//   imem_ready  mem -> fetch   completion strobe, may coincide with req rising
//
// master: the fetch stage.  slave: the memory.
// -----------------------------------------------------------------------------
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage feeding decode.  Holds the PC, issues requests to a
// variable-latency instruction memory, drives the IF/ID register and accepts
// redirects from decode (jump/register jump) and execute (taken branch).
// A one-entry skid buffer catches a response that lands during a stall.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous active-high reset
//   stall          freeze IF/ID (hazard)
//   jmp_sel        00 seq, 01 absolute jump, 10 register jump, 11 no redirect
//   jump_addr      absolute jump target
//   reg_target     register jump target
//   branch_taken   execute resolved a taken branch (overrides stall)
//   branch_target  branch target
//   imem           instruction memory bus (master side)
//   instr_id       IF/ID instruction (0 = NOP on a bubble)
//   pc_id          IF/ID PC of instr_id
//   valid_id       IF/ID holds a real instruction
//
// States
//   state | meaning
//   IDLE  | first cycle after reset, no request yet
//   REQ   | request to pc outstanding (or about to complete)
//   BUF   | response captured in skid buffer, waiting for stall to drop
//   DROP  | stale request still in flight after a redirect; its data is
//         | thrown away when it completes
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [1:0]           jmp_sel,
    input  logic [31:0]          jump_addr,
    input  logic [31:0]          reg_target,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    instr_fetch_if.master        imem,
    output logic [31:0]          instr_id,
    output logic [31:0]          pc_id,
    output logic                 valid_id
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUF  = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        req_q;
    logic [31:0] addr_q;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_next;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign pc_next        = pc + STEP;

    // Decode-side jumps only count when decode is actually consuming a valid
    // entry; a taken branch from execute always wins, even under stall.
    always_comb begin
        redirect = 1'b0;
        target   = branch_target;
        if (branch_taken) begin
            redirect = 1'b1;
            target   = branch_target;
        end else if (valid_id && !stall) begin
            case (jmp_sel)
                2'b01: begin
                    redirect = 1'b1;
                    target   = jump_addr;
                end
                2'b10: begin
                    redirect = 1'b1;
                    target   = reg_target;
                end
                default: begin
                    redirect = 1'b0;
                    target   = branch_target;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            skid_instr <= 32'h0000_0000;
            skid_pc    <= 32'h0000_0000;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_id   <= 32'h0000_0000;
            pc_id      <= 32'h0000_0000;
            valid_id   <= 1'b0;
        end else if (redirect) begin
            pc       <= target;
            valid_id <= 1'b0;
            instr_id <= 32'h0000_0000;
            if (req_q && !imem.imem_ready) begin
                // Old request must still complete once; keep req/addr as-is.
                state <= DROP;
            end else begin
                state  <= REQ;
                req_q  <= 1'b1;
                addr_q <= target;
            end
        end else begin
            case (state)
                IDLE: begin
                    state  <= REQ;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                end

                REQ: begin
                    if (imem.imem_ready) begin
                        pc     <= pc_next;
                        addr_q <= pc_next;
                        if (!stall) begin
                            valid_id <= 1'b1;
                            instr_id <= imem.imem_rdata;
                            pc_id    <= pc;
                        end else begin
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= pc;
                            req_q      <= 1'b0;
                            state      <= BUF;
                        end
                    end else if (!stall) begin
                        valid_id <= 1'b0;
                        instr_id <= 32'h0000_0000;
                    end
                end

                BUF: begin
                    if (!stall) begin
                        valid_id <= 1'b1;
                        instr_id <= skid_instr;
                        pc_id    <= skid_pc;
                        req_q    <= 1'b1;
                        addr_q   <= pc;
                        state    <= REQ;
                    end
                end

                DROP: begin
                    if (!stall) begin
                        valid_id <= 1'b0;
                        instr_id <= 32'h0000_0000;
                    end
                    if (imem.imem_ready) begin
                        addr_q <= pc;
                        state  <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
